// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: command opcodes, the receive
// parser state enumeration and the fixed ALU operand register addresses.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam logic [3:0] OPA_ADDR = 4'd0;
    localparam logic [3:0] OPB_ADDR = 4'd1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_ADDR  = 4'd1,
        ST_WR_DATA  = 4'd2,
        ST_RD_ADDR  = 4'd3,
        ST_RD_WAIT  = 4'd4,
        ST_OP_A     = 4'd5,
        ST_OP_B     = 4'd6,
        ST_ALU_FUN  = 4'd7,
        ST_ALU_WAIT = 4'd8,
        ST_TX_LO    = 4'd9,
        ST_TX_HI    = 4'd10
    } rx_state_e;

endpackage

// File: rtl/rx_frame_parser.sv
// Receive/command half of the system controller: parses synchronized command
// frames into register-file and ALU strobes and pushes responses to the TX FIFO.
module rx_frame_parser
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
    input  logic                    RF_RD_DATA_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    FIFO_FULL,
    output logic                    RF_WR_EN,
    output logic                    RF_RD_EN,
    output logic [ADDR_WIDTH-1:0]   RF_ADDR,
    output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
    output logic                    ALU_EN,
    output logic [3:0]              ALU_FUN,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_DATA,
    output logic                    TX_WR_INC,
    output logic                    ERR
);

    localparam int RW = 2 * DATA_WIDTH;

    localparam logic [DATA_WIDTH-1:0] OPC_WR      = DATA_WIDTH'(CMD_WR);
    localparam logic [DATA_WIDTH-1:0] OPC_RD      = DATA_WIDTH'(CMD_RD);
    localparam logic [DATA_WIDTH-1:0] OPC_ALU_OP  = DATA_WIDTH'(CMD_ALU_OP);
    localparam logic [DATA_WIDTH-1:0] OPC_ALU_NOP = DATA_WIDTH'(CMD_ALU_NOP);
    localparam logic [ADDR_WIDTH-1:0] OPA_A       = ADDR_WIDTH'(OPA_ADDR);
    localparam logic [ADDR_WIDTH-1:0] OPB_A       = ADDR_WIDTH'(OPB_ADDR);
    // The abort fires on the cycle whose increment would make the count reach TIMEOUT.
    localparam logic [7:0]            TMO_LAST    = 8'(TIMEOUT - 1);

    rx_state_e             state_r, state_s;
    logic [ADDR_WIDTH-1:0] wr_addr_r, wr_addr_s;
    logic [RW-1:0]         rsp_r, rsp_s;
    logic                  rsp_alu_r, rsp_alu_s;
    logic [7:0]            tmo_cnt_r;
    logic                  tmo_run_s, tmo_hit_s;
    logic                  tx_push_s;
    logic [DATA_WIDTH-1:0] tx_byte_s;

    logic                  rf_wr_en_r, rf_wr_en_s;
    logic                  rf_rd_en_r, rf_rd_en_s;
    logic [ADDR_WIDTH-1:0] rf_addr_r, rf_addr_s;
    logic [DATA_WIDTH-1:0] rf_wr_data_r, rf_wr_data_s;
    logic                  alu_en_r, alu_en_s;
    logic [3:0]            alu_fun_r, alu_fun_s;
    logic                  clk_gate_en_r, clk_gate_en_s;
    logic [DATA_WIDTH-1:0] tx_data_r;
    logic                  tx_wr_inc_r;
    logic                  err_r, err_s;

    assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);
    assign tmo_run_s = ((state_r == ST_RD_WAIT) || (state_r == ST_ALU_WAIT)) && (state_s == state_r);

    // TX byte sequencer: a push is decided from FIFO_FULL in the cycle before it appears.
    always_comb begin
        tx_push_s = 1'b0;
        tx_byte_s = tx_data_r;
        case (state_r)
            ST_RD_WAIT: begin
                if (RF_RD_DATA_VLD && !FIFO_FULL) begin
                    tx_push_s = 1'b1;
                    tx_byte_s = RF_RD_DATA;
                end else begin
                    tx_push_s = 1'b0;
                end
            end
            ST_ALU_WAIT: begin
                if (ALU_OUT_VLD && !FIFO_FULL) begin
                    tx_push_s = 1'b1;
                    tx_byte_s = ALU_OUT[DATA_WIDTH-1:0];
                end else begin
                    tx_push_s = 1'b0;
                end
            end
            ST_TX_LO: begin
                if (!FIFO_FULL) begin
                    tx_push_s = 1'b1;
                    tx_byte_s = rsp_r[DATA_WIDTH-1:0];
                end else begin
                    tx_push_s = 1'b0;
                end
            end
            ST_TX_HI: begin
                if (!FIFO_FULL) begin
                    tx_push_s = 1'b1;
                    tx_byte_s = rsp_r[RW-1:DATA_WIDTH];
                end else begin
                    tx_push_s = 1'b0;
                end
            end
            default: begin
                tx_push_s = 1'b0;
            end
        endcase
    end

    // Frame FSM next-state and next-output logic; strobes default low, data outputs hold.
    always_comb begin
        state_s      = state_r;
        wr_addr_s    = wr_addr_r;
        rsp_s        = rsp_r;
        rsp_alu_s    = rsp_alu_r;
        rf_wr_en_s   = 1'b0;
        rf_rd_en_s   = 1'b0;
        alu_en_s     = 1'b0;
        err_s        = 1'b0;
        rf_addr_s    = rf_addr_r;
        rf_wr_data_s = rf_wr_data_r;
        alu_fun_s    = alu_fun_r;
        case (state_r)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        OPC_WR:      state_s = ST_WR_ADDR;
                        OPC_RD:      state_s = ST_RD_ADDR;
                        OPC_ALU_OP:  state_s = ST_OP_A;
                        OPC_ALU_NOP: state_s = ST_ALU_FUN;
                        default:     state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR_ADDR: begin
                if (RX_D_VLD) begin
                    wr_addr_s = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_s   = ST_WR_DATA;
                end else begin
                    state_s = ST_WR_ADDR;
                end
            end
            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    rf_wr_en_s   = 1'b1;
                    rf_addr_s    = wr_addr_r;
                    rf_wr_data_s = RX_P_DATA;
                    state_s      = ST_IDLE;
                end else begin
                    state_s = ST_WR_DATA;
                end
            end
            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    rf_rd_en_s = 1'b1;
                    rf_addr_s  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_s    = ST_RD_WAIT;
                end else begin
                    state_s = ST_RD_ADDR;
                end
            end
            ST_RD_WAIT: begin
                if (RF_RD_DATA_VLD) begin
                    rsp_s     = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
                    rsp_alu_s = 1'b0;
                    state_s   = tx_push_s ? ST_IDLE : ST_TX_LO;
                end else if (tmo_hit_s) begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RD_WAIT;
                end
            end
            ST_OP_A: begin
                if (RX_D_VLD) begin
                    rf_wr_en_s   = 1'b1;
                    rf_addr_s    = OPA_A;
                    rf_wr_data_s = RX_P_DATA;
                    state_s      = ST_OP_B;
                end else begin
                    state_s = ST_OP_A;
                end
            end
            ST_OP_B: begin
                if (RX_D_VLD) begin
                    rf_wr_en_s   = 1'b1;
                    rf_addr_s    = OPB_A;
                    rf_wr_data_s = RX_P_DATA;
                    state_s      = ST_ALU_FUN;
                end else begin
                    state_s = ST_OP_B;
                end
            end
            ST_ALU_FUN: begin
                if (RX_D_VLD) begin
                    alu_en_s  = 1'b1;
                    alu_fun_s = RX_P_DATA[3:0];
                    state_s   = ST_ALU_WAIT;
                end else begin
                    state_s = ST_ALU_FUN;
                end
            end
            ST_ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    rsp_s     = ALU_OUT;
                    rsp_alu_s = 1'b1;
                    state_s   = tx_push_s ? ST_TX_HI : ST_TX_LO;
                end else if (tmo_hit_s) begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ALU_WAIT;
                end
            end
            ST_TX_LO: begin
                if (tx_push_s) begin
                    state_s = rsp_alu_r ? ST_TX_HI : ST_IDLE;
                end else begin
                    state_s = ST_TX_LO;
                end
            end
            ST_TX_HI: begin
                if (tx_push_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_TX_HI;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Gate covers ALU_FUN/ALU_WAIT; ALU_EN always lands in the first ALU_WAIT cycle.
        clk_gate_en_s = (state_s == ST_ALU_FUN) || (state_s == ST_ALU_WAIT);
    end

    // Wait-state timeout counter: counts while staying in a wait state, clears otherwise.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tmo_cnt_r <= 8'd0;
        end else if (tmo_run_s) begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end else begin
            tmo_cnt_r <= 8'd0;
        end
    end

    // State, latched frame fields and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r       <= ST_IDLE;
            wr_addr_r     <= {ADDR_WIDTH{1'b0}};
            rsp_r         <= {RW{1'b0}};
            rsp_alu_r     <= 1'b0;
            rf_wr_en_r    <= 1'b0;
            rf_rd_en_r    <= 1'b0;
            rf_addr_r     <= {ADDR_WIDTH{1'b0}};
            rf_wr_data_r  <= {DATA_WIDTH{1'b0}};
            alu_en_r      <= 1'b0;
            alu_fun_r     <= 4'd0;
            clk_gate_en_r <= 1'b0;
            tx_data_r     <= {DATA_WIDTH{1'b0}};
            tx_wr_inc_r   <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            state_r       <= state_s;
            wr_addr_r     <= wr_addr_s;
            rsp_r         <= rsp_s;
            rsp_alu_r     <= rsp_alu_s;
            rf_wr_en_r    <= rf_wr_en_s;
            rf_rd_en_r    <= rf_rd_en_s;
            rf_addr_r     <= rf_addr_s;
            rf_wr_data_r  <= rf_wr_data_s;
            alu_en_r      <= alu_en_s;
            alu_fun_r     <= alu_fun_s;
            clk_gate_en_r <= clk_gate_en_s;
            tx_data_r     <= tx_byte_s;
            tx_wr_inc_r   <= tx_push_s;
            err_r         <= err_s;
        end
    end

    assign RF_WR_EN    = rf_wr_en_r;
    assign RF_RD_EN    = rf_rd_en_r;
    assign RF_ADDR     = rf_addr_r;
    assign RF_WR_DATA  = rf_wr_data_r;
    assign ALU_EN      = alu_en_r;
    assign ALU_FUN     = alu_fun_r;
    assign CLK_GATE_EN = clk_gate_en_r;
    assign TX_DATA     = tx_data_r;
    assign TX_WR_INC   = tx_wr_inc_r;
    assign ERR         = err_r;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Self-checking bench for rx_frame_parser: the bench plays register file, ALU and
// TX FIFO, and compares every strobe and response against its own frame model.
module tb_rx_frame_parser;

    localparam int TMO = 255;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = 8'h00;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  RF_RD_DATA = 8'h00;
    logic        RF_RD_DATA_VLD = 1'b0;
    logic [15:0] ALU_OUT = 16'h0000;
    logic        ALU_OUT_VLD = 1'b0;
    logic        FIFO_FULL = 1'b0;
    logic        RF_WR_EN, RF_RD_EN, ALU_EN, CLK_GATE_EN, TX_WR_INC, ERR;
    logic [3:0]  RF_ADDR, ALU_FUN;
    logic [7:0]  RF_WR_DATA, TX_DATA;

    int n_cmp = 0;
    int n_fail = 0;
    int wr_seen = 0, rd_seen = 0, alu_seen = 0, tx_seen = 0, err_seen = 0;
    logic [7:0] mem [16];

    always #5 CLK = ~CLK;

    rx_frame_parser #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL),
        .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN), .RF_ADDR(RF_ADDR),
        .RF_WR_DATA(RF_WR_DATA), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
        .CLK_GATE_EN(CLK_GATE_EN), .TX_DATA(TX_DATA), .TX_WR_INC(TX_WR_INC), .ERR(ERR)
    );

    // Strobe counters sampled just after each rising edge.
    always begin
        @(posedge CLK);
        #1;
        if (RF_WR_EN)  wr_seen++;
        if (RF_RD_EN)  rd_seen++;
        if (ALU_EN)    alu_seen++;
        if (TX_WR_INC) tx_seen++;
        if (ERR)       err_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'($urandom);
    endtask

    // Plays RF or ALU returning val, drives FIFO_FULL (held for full_hold cycles from the
    // valid cycle, then random at full_pct %), and records pushes plus handshake violations.
    task automatic respond(input logic is_alu, input logic [15:0] val, input int full_hold,
                           input int full_pct, output logic [7:0] b0, output logic [7:0] b1,
                           output int npush, output int viol, output int first_push);
        int remaining;
        logic full_edge;
        remaining = is_alu ? 2 : 1;
        npush = 0; viol = 0; first_push = -1; b0 = 8'h00; b1 = 8'h00;
        @(negedge CLK);
        if (is_alu) begin ALU_OUT = val; ALU_OUT_VLD = 1'b1; end
        else begin RF_RD_DATA = val[7:0]; RF_RD_DATA_VLD = 1'b1; end
        FIFO_FULL = (full_hold > 0) ? 1'b1 : ($urandom_range(0, 99) < full_pct);
        full_edge = FIFO_FULL;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge CLK);
            ALU_OUT_VLD = 1'b0;
            RF_RD_DATA_VLD = 1'b0;
            if (TX_WR_INC) begin
                if (full_edge || remaining == 0) viol++;
                if (npush == 0) begin b0 = TX_DATA; first_push = cyc; end
                else if (npush == 1) b1 = TX_DATA;
                npush++;
                if (remaining > 0) remaining--;
            end else if (!full_edge && remaining > 0) begin
                viol++;
            end
            if (remaining == 0) break;
            if (cyc + 1 < full_hold) FIFO_FULL = 1'b1;
            else if (cyc >= 200) FIFO_FULL = 1'b0;
            else FIFO_FULL = ($urandom_range(0, 99) < full_pct);
            full_edge = FIFO_FULL;
        end
        if (remaining > 0) viol++;
        FIFO_FULL = 1'b0;
        @(negedge CLK);
        if (TX_WR_INC) viol++;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        #1;
        n_cmp++; if ({RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_DATA, TX_WR_INC, ERR} !== 30'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", {RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_DATA, TX_WR_INC, ERR}); end
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        n_cmp++; if ({RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_DATA, TX_WR_INC, ERR} !== 30'd0) begin n_fail++; $display("FAIL after_release_outputs: got %h want 0", {RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_DATA, TX_WR_INC, ERR}); end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        int w0;
        w0 = wr_seen;
        send_byte(8'hAA);
        send_byte({4'($urandom), a});
        n_cmp++; if (RF_WR_EN !== 1'b0) begin n_fail++; $display("FAIL wr_early: got %b want 0", RF_WR_EN); end
        send_byte(d);
        n_cmp++; if (RF_WR_EN !== 1'b1) begin n_fail++; $display("FAIL wr_strobe: got %b want 1", RF_WR_EN); end
        n_cmp++; if (RF_ADDR !== a) begin n_fail++; $display("FAIL wr_addr: got %h want %h", RF_ADDR, a); end
        n_cmp++; if (RF_WR_DATA !== d) begin n_fail++; $display("FAIL wr_data: got %h want %h", RF_WR_DATA, d); end
        @(negedge CLK);
        n_cmp++; if ({RF_WR_EN, RF_ADDR, RF_WR_DATA} !== {1'b0, a, d}) begin n_fail++; $display("FAIL wr_hold: got %h want %h", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b0, a, d}); end
        n_cmp++; if (wr_seen - w0 !== 1) begin n_fail++; $display("FAIL wr_count: got %0d want 1", wr_seen - w0); end
        mem[a] = d;
    endtask

    task automatic test_write();
        do_write(4'h5, 8'h3C);
        for (int i = 0; i < 8; i++) do_write(4'($urandom), 8'($urandom));
    endtask

    task automatic do_read(input logic [3:0] a, input int dly, input logic stray, input int pct);
        logic [7:0] b0, b1;
        int np, viol, fp, r0, a0, e0;
        a0 = alu_seen; e0 = err_seen;
        send_byte(8'hBB);
        r0 = rd_seen;
        send_byte({4'($urandom), a});
        n_cmp++; if ({RF_RD_EN, RF_ADDR} !== {1'b1, a}) begin n_fail++; $display("FAIL rd_strobe: got %h want %h", {RF_RD_EN, RF_ADDR}, {1'b1, a}); end
        repeat (dly) @(negedge CLK);
        if (stray) send_byte(8'hDD);
        respond(1'b0, {8'h00, mem[RF_ADDR]}, 0, pct, b0, b1, np, viol, fp);
        n_cmp++; if (b0 !== mem[a]) begin n_fail++; $display("FAIL rd_tx_data: got %h want %h", b0, mem[a]); end
        n_cmp++; if ({np, viol} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL rd_tx_proto: pushes %0d violations %0d want 1/0", np, viol); end
        n_cmp++; if ({rd_seen - r0, alu_seen - a0, err_seen - e0, 31'd0, CLK_GATE_EN} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin n_fail++; $display("FAIL rd_side_effects: rd %0d alu %0d err %0d gate %b want 1/0/0/0", rd_seen - r0, alu_seen - a0, err_seen - e0, CLK_GATE_EN); end
    endtask

    task automatic test_read();
        do_read(4'h5, 2, 1'b0, 0);
        do_read(4'($urandom), 3, 1'b1, 0);
        for (int i = 0; i < 6; i++) do_read(4'($urandom), $urandom_range(0, 20), 1'($urandom), 30);
    endtask

    task automatic do_alu(input logic with_ops, input logic [7:0] opa, input logic [7:0] opb,
                          input logic [3:0] fun, input logic [15:0] res, input int dly,
                          input int hold, input int pct, input int exp_first);
        logic [7:0] b0, b1;
        int np, viol, fp, gate_low, a0;
        gate_low = 0;
        a0 = alu_seen;
        if (with_ops) begin
            send_byte(8'hCC);
            send_byte(opa);
            n_cmp++; if ({RF_WR_EN, RF_ADDR, RF_WR_DATA} !== {1'b1, 4'h0, opa}) begin n_fail++; $display("FAIL opa_write: got %h want %h", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'h0, opa}); end
            send_byte(opb);
            n_cmp++; if ({RF_WR_EN, RF_ADDR, RF_WR_DATA} !== {1'b1, 4'h1, opb}) begin n_fail++; $display("FAIL opb_write: got %h want %h", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'h1, opb}); end
            mem[0] = opa; mem[1] = opb;
        end else begin
            send_byte(8'hDD);
        end
        n_cmp++; if (CLK_GATE_EN !== 1'b1) begin n_fail++; $display("FAIL gate_in_fun: got %b want 1", CLK_GATE_EN); end
        send_byte({4'($urandom), fun});
        n_cmp++; if ({ALU_EN, ALU_FUN, CLK_GATE_EN} !== {1'b1, fun, 1'b1}) begin n_fail++; $display("FAIL alu_strobe: got %h want %h", {ALU_EN, ALU_FUN, CLK_GATE_EN}, {1'b1, fun, 1'b1}); end
        for (int i = 0; i < dly; i++) begin
            @(negedge CLK);
            if (CLK_GATE_EN !== 1'b1) gate_low++;
        end
        n_cmp++; if (gate_low !== 0) begin n_fail++; $display("FAIL gate_in_wait: low cycles %0d want 0", gate_low); end
        respond(1'b1, res, hold, pct, b0, b1, np, viol, fp);
        n_cmp++; if ({b0, b1} !== {res[7:0], res[15:8]}) begin n_fail++; $display("FAIL alu_tx_bytes: got %h want %h", {b0, b1}, {res[7:0], res[15:8]}); end
        n_cmp++; if ({np, viol} !== {32'd2, 32'd0}) begin n_fail++; $display("FAIL alu_tx_proto: pushes %0d violations %0d want 2/0", np, viol); end
        if (exp_first >= 0) begin
            n_cmp++; if (fp !== exp_first) begin n_fail++; $display("FAIL alu_first_push: cycle %0d want %0d", fp, exp_first); end
        end
        n_cmp++; if ({alu_seen - a0, 31'd0, CLK_GATE_EN} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL alu_after: alu strobes %0d gate %b want 1/0", alu_seen - a0, CLK_GATE_EN); end
    endtask

    task automatic test_alu_op();
        logic [7:0] a, b;
        do_alu(1'b1, 8'h10, 8'h20, 4'h0, 16'h0030, 4, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            do_alu(1'b1, a, b, 4'($urandom), 16'($urandom), $urandom_range(0, 15), $urandom_range(0, 3), 40, -1);
        end
    endtask

    task automatic test_alu_nop_full();
        do_alu(1'b0, 8'h00, 8'h00, 4'h2, 16'h1234, 2, 11, 0, 11);
        for (int i = 0; i < 3; i++)
            do_alu(1'b0, 8'h00, 8'h00, 4'($urandom), 16'($urandom), $urandom_range(0, 10), $urandom_range(0, 5), 50, -1);
    endtask

    task automatic test_timeout();
        logic [7:0] b0, b1;
        int np, viol, fp, err_at, t0, e0;
        err_at = -1;
        t0 = tx_seen;
        send_byte(8'hBB);
        send_byte(8'h07);
        n_cmp++; if ({RF_RD_EN, RF_ADDR} !== {1'b1, 4'h7}) begin n_fail++; $display("FAIL tmo_rd_strobe: got %h want 17", {RF_RD_EN, RF_ADDR}); end
        for (int c = 1; c <= 2 * TMO + 20; c++) begin
            @(negedge CLK);
            if (ERR === 1'b1) begin err_at = c; break; end
        end
        n_cmp++; if (err_at !== TMO) begin n_fail++; $display("FAIL tmo_err_cycle: got %0d want %0d", err_at, TMO); end
        @(negedge CLK);
        n_cmp++; if ({ERR, tx_seen - t0} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL tmo_after: err %b pushes %0d want 0/0", ERR, tx_seen - t0); end
        // A valid on the last wait cycle still wins over the abort.
        e0 = err_seen;
        send_byte(8'hBB);
        send_byte(8'h08);
        repeat (TMO - 2) @(negedge CLK);
        respond(1'b0, {8'h00, mem[8]}, 0, 0, b0, b1, np, viol, fp);
        n_cmp++; if ({b0, np, viol, err_seen - e0} !== {mem[8], 32'd1, 32'd0, 32'd0}) begin n_fail++; $display("FAIL tmo_last_valid: data %h pushes %0d viol %0d err %0d want %h/1/0/0", b0, np, viol, err_seen - e0, mem[8]); end
        do_write(4'h1, 8'hFF);
    endtask

    task automatic test_reset_mid();
        int w0;
        send_byte(8'hAA);
        send_byte(8'h03);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        n_cmp++; if ({RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_DATA, TX_WR_INC, ERR} !== 30'd0) begin n_fail++; $display("FAIL midframe_reset_outputs: got %h want 0", {RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_DATA, TX_WR_INC, ERR}); end
        @(negedge CLK);
        RST = 1'b1;
        w0 = wr_seen;
        send_byte(8'h77);
        @(negedge CLK);
        n_cmp++; if (wr_seen - w0 !== 0) begin n_fail++; $display("FAIL partial_frame_discard: writes %0d want 0", wr_seen - w0); end
        do_write(4'hA, 8'h5A);
    endtask

    task automatic test_stray();
        logic [7:0] b;
        int w0, r0, a0, t0;
        w0 = wr_seen; r0 = rd_seen; a0 = alu_seen; t0 = tx_seen;
        send_byte(8'h55);
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'($urandom);
            send_byte(b);
        end
        @(negedge CLK);
        n_cmp++; if ({wr_seen - w0, rd_seen - r0, alu_seen - a0, tx_seen - t0, 31'd0, CLK_GATE_EN} !== 160'd0) begin n_fail++; $display("FAIL stray_ignored: wr %0d rd %0d alu %0d tx %0d gate %b want all 0", wr_seen - w0, rd_seen - r0, alu_seen - a0, tx_seen - t0, CLK_GATE_EN); end
        do_write(4'h2, 8'h44);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_alu_op();
        test_alu_nop_full();
        test_timeout();
        test_reset_mid();
        test_stray();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
